// File: rtl/muxpga_pkg.sv
// Shared constants for the mux-based 7-segment fabric: LUT count, chain width, default font.
// Build option MUXPGA_DP_EN adds an eighth LUT driving the decimal point.
package muxpga_pkg;

    localparam int NSEG = 7;
`ifdef MUXPGA_DP_EN
    localparam int NLUT = NSEG + 1;
`else
    localparam int NLUT = NSEG;
`endif
    localparam int CFG_W = 16 * NLUT;

    // Hex font, gfedcba, indexed by digit 0..F
    localparam logic [6:0] DEFAULT_FONT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Transpose the font so each LUT owns one 16-bit column; the DP column lights odd digits.
    function automatic logic [CFG_W-1:0] font_to_chain();
        logic [CFG_W-1:0] chain;
        logic [6:0]       glyph;
        chain = '0;
        for (int i = 0; i < 16; i++) begin
            glyph = DEFAULT_FONT[i];
            for (int k = 0; k < NLUT; k++) begin
                chain[16*k + i] = (k < NSEG) ? glyph[k] : (i % 2 == 1);
            end
        end
        return chain;
    endfunction

endpackage

// File: rtl/muxpga_lut4.sv
// Four-input LUT built as an explicit four-level 2:1 mux tree over 16 configuration bits.
// Unaffected by MUXPGA_DP_EN; the top decides how many are instantiated.
module muxpga_lut4
    import muxpga_pkg::*;
(
    input  logic [15:0] i_cfg,
    input  logic [3:0]  i_sel,
    output logic        o_out
);

    logic [7:0] w_l1;
    logic [3:0] w_l2;
    logic [1:0] w_l3;

    genvar g;
    for (g = 0; g < 8; g++) begin : g_l1
        assign w_l1[g] = i_sel[0] ? i_cfg[2*g+1] : i_cfg[2*g];
    end
    for (g = 0; g < 4; g++) begin : g_l2
        assign w_l2[g] = i_sel[1] ? w_l1[2*g+1] : w_l1[2*g];
    end
    for (g = 0; g < 2; g++) begin : g_l3
        assign w_l3[g] = i_sel[2] ? w_l2[2*g+1] : w_l2[2*g];
    end

    assign o_out = i_sel[3] ? w_l3[1] : w_l3[0];

endmodule

// File: rtl/diferential_muxpga_core.sv
// Top of the mux fabric: io mapping, prescaler, digit counter and serial config chain.
// Define MUXPGA_DP_EN to drive io_out[7] from an eighth LUT instead of tying it low.
module diferential_muxpga_core
    import muxpga_pkg::*;
#(
    parameter int DIV = 1000
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CFG_W-1:0] FONT_CHAIN = font_to_chain();

    logic w_clk, w_rst, w_cfg_din, w_cfg_en, w_hex, w_hold, w_unused;
    assign w_clk     = io_in[0];
    assign w_rst     = io_in[1];
    assign w_cfg_din = io_in[2];
    assign w_cfg_en  = io_in[3];
    assign w_hex     = io_in[4];
    assign w_hold    = io_in[5];
    assign w_unused  = &io_in[7:6];

    logic [PW-1:0]    r_presc;
    logic [3:0]       r_digit;
    logic [CFG_W-1:0] r_chain;
    logic [3:0]       w_digit_nxt;
    logic [NLUT-1:0]  w_seg;

    // Decimal mode also recovers from A..F left over after switching out of hex mode.
    always_comb begin
        w_digit_nxt = 4'd0;
        if (w_hex || (r_digit < 4'd9)) begin
            w_digit_nxt = r_digit + 4'd1;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_presc <= '0;
            r_digit <= '0;
            r_chain <= FONT_CHAIN;
        end else if (w_cfg_en) begin
            r_chain <= {r_chain[CFG_W-2:0], w_cfg_din};
        end else if (!w_hold) begin
            if (r_presc == PW'(DIV - 1)) begin
                r_presc <= '0;
                r_digit <= w_digit_nxt;
            end else begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

    genvar g;
    for (g = 0; g < NLUT; g++) begin : g_lut
        muxpga_lut4 u_lut (
            .i_cfg (r_chain[16*g +: 16]),
            .i_sel (r_digit),
            .o_out (w_seg[g])
        );
    end

`ifdef MUXPGA_DP_EN
    assign io_out = w_seg;
`else
    assign io_out = {1'b0, w_seg};
`endif

endmodule

// File: tb/tb_diferential_muxpga_core.sv
// Scoreboard bench for diferential_muxpga_core with a short DIV; honours MUXPGA_DP_EN.
module tb_diferential_muxpga_core;

    localparam int DIV = 12;
`ifdef MUXPGA_DP_EN
    localparam int NL = 8;
`else
    localparam int NL = 7;
`endif
    localparam int N = 16 * NL;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    logic clk = 1'b0, rst = 1'b0, cfg_din = 1'b0, cfg_en = 1'b0, hex = 1'b0, hold = 1'b0;
    logic [7:0] io_in, io_out;
    assign io_in = {2'b00, hold, hex, cfg_en, cfg_din, rst, clk};

    diferential_muxpga_core #(.DIV(DIV)) dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q [$];

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h, expected %02h", tag, act, exp);
        end
    endtask

    function automatic logic [6:0] font(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F; 10: return 7'h77; 11: return 7'h7C;
           12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    function automatic logic [7:0] exp_out(input int d);
        logic dp;
`ifdef MUXPGA_DP_EN
        dp = (d % 2 == 1);
`else
        dp = 1'b0;
`endif
        return {dp, font(d)};
    endfunction

    function automatic logic [N-1:0] ref_chain();
        logic [N-1:0] c;
        logic [6:0]   f;
        c = '0;
        for (int i = 0; i < 16; i++) begin
            f = font(i);
            for (int k = 0; k < NL; k++) c[16*k + i] = (k < 7) ? f[k] : (i % 2 == 1);
        end
        return c;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic [7:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 8'h01, 8'h00);
        end else begin
            e = exp_q.pop_front();
            check(e.tag, io_out, e.val);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; cfg_en = 1'b0; cfg_din = 1'b0; hex = 1'b0; hold = 1'b0;
        tick(1);
        rst = 1'b0;
    endtask

    logic [N-1:0] chain;
    logic [7:0]   v;

    initial begin
        // Reset and decimal counting
        do_reset();
        push_exp("reset", exp_out(0));        check_out();
        push_exp("pre_step", exp_out(0));     tick(DIV - 1); check_out();
        push_exp("step1", exp_out(1));        tick(1);       check_out();
        push_exp("step2", exp_out(2));        tick(DIV);     check_out();
        push_exp("dec_9", exp_out(9));        tick(7 * DIV); check_out();
        push_exp("dec_wrap", exp_out(0));     tick(DIV);     check_out();

        // Hex counting
        do_reset();
        hex = 1'b1;
        push_exp("hex_A", exp_out(10));       tick(10 * DIV); check_out();
        push_exp("hex_F", exp_out(15));       tick(5 * DIV);  check_out();
        push_exp("hex_wrap", exp_out(0));     tick(DIV);      check_out();

        // Leaving hex mode at digit B returns to 0 on the next step
        do_reset();
        hex = 1'b1;
        push_exp("hex_B", exp_out(11));       tick(11 * DIV); check_out();
        hex = 1'b0;
        push_exp("mode_change", exp_out(0));  tick(DIV);      check_out();

        // Config load with digit frozen at 3, prescaler at 5
        do_reset();
        push_exp("pre_cfg", exp_out(3));      tick(3 * DIV + 5); check_out();
        cfg_en = 1'b1; cfg_din = 1'b1;
        push_exp("cfg_ones", (NL == 8) ? 8'hFF : 8'h7F); tick(N); check_out();
        cfg_din = 1'b0;
        push_exp("cfg_zeros", 8'h00);         tick(N); check_out();
        chain = ref_chain();
        push_exp("cfg_reload", exp_out(3));
        for (int b = N - 1; b >= 0; b--) begin
            cfg_din = chain[b];
            tick(1);
        end
        check_out();
        cfg_en = 1'b0; cfg_din = 1'b0;
        push_exp("cfg_resume_hold", exp_out(3)); tick(DIV - 6); check_out();
        push_exp("cfg_resume_step", exp_out(4)); tick(1);       check_out();

        // Hold freezes prescaler and digit
        do_reset();
        push_exp("pre_hold", exp_out(2));     tick(2 * DIV + 4); check_out();
        hold = 1'b1;
        push_exp("hold", exp_out(2));         tick(3 * DIV);     check_out();
        hold = 1'b0;
        push_exp("post_hold", exp_out(2));    tick(DIV - 5);     check_out();
        push_exp("hold_resume", exp_out(3));  tick(1);           check_out();

        // Reset aborts a partial load and restores the font
        do_reset();
        cfg_en = 1'b1; cfg_din = 1'b0;
        chain = ref_chain() << 50;
        v = '0;
        for (int k = 0; k < NL; k++) v[k] = chain[16*k];
        push_exp("partial_load", v);          tick(50); check_out();
        rst = 1'b1; cfg_din = 1'b1;
        push_exp("rst_abort", exp_out(0));    tick(1);  check_out();
        rst = 1'b0; cfg_en = 1'b0; cfg_din = 1'b0;
        push_exp("abort_step", exp_out(1));   tick(DIV); check_out();

        if (exp_q.size() != 0) check("scoreboard_left", 8'(exp_q.size()), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
